mvau_weight_loader: RTL and testbench
=====================================

# mvau_weight_loader

Runtime writer for the MVAU weight memories: accepts a stream of SIMD×TW-bit weight words on an AXI-Stream slave and writes them into the PE weight memory banks. It is the write-side counterpart of the per-PE weight memory read port. It sits between the DMA/weight stream input and the PE weight banks, and asserts busy so the MVAU control holds compute while a reload is in flight.

## Interface
Parameters:
- SIMD, 2: weight lanes per word.
- TW, 1: bits per weight.
- PE, 2: number of weight memory banks.
- WMEM_DEPTH, 4: words per bank.
- WMEM_ADDR_BW, 4: bank address width, must be ≥ clog2(WMEM_DEPTH).

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  reset, asynchronous and active-high.
- cfg_start  in  1  single-cycle request to begin a full reload.
- s_axis_tdata  in  SIMD*TW  weight word.
- s_axis_tvalid  in  1  word valid.
- s_axis_tlast  in  1  marks the final word of a reload.
- s_axis_tready  out  1  loader ready.
- wmem_we  out  PE  one-hot write enable, bit p selects bank p.
- wmem_waddr  out  WMEM_ADDR_BW  write address, common to all banks.
- wmem_wdata  out  SIMD*TW  write data, common to all banks.
- wmem_busy  out  1  reload in progress.
- load_done  out  1  single-cycle pulse at reload end.
- load_err  out  1  sticky framing error flag.

## Operation
- States:
  - IDLE: tready=0, busy=0.
  - LOAD: tready=1, busy=1.
- Counters:
  - pe_cnt runs 0..PE-1.
  - addr_cnt runs 0..WMEM_DEPTH-1.
  - Beat order is address-major: for each address, PE0..PE-1.
  - Total beats N = PE*WMEM_DEPTH.
- IDLE → LOAD on cfg_start=1:
  - Clears pe_cnt, addr_cnt and load_err.
  - cfg_start is ignored while in LOAD.
- Accepted beat (tvalid & tready):
  - Registers wmem_we = onehot(pe_cnt), wmem_waddr = addr_cnt and wmem_wdata = tdata.
  - pe_cnt increments. On wrap from PE-1 to 0, addr_cnt increments.
- Final beat (pe_cnt=PE-1 and addr_cnt=WMEM_DEPTH-1) accepted:
  - LOAD → IDLE.
  - If tlast=0, load_err is set.
- Early tlast (tlast=1 on a non-final beat):
  - That beat is still written.
  - load_err is set.
  - LOAD → IDLE; the remaining words are not written.
- load_done pulses on every LOAD → IDLE exit, whether the load completed or aborted.
- No beat is accepted in IDLE. Upstream data arriving in IDLE stalls.
- wmem_we is 0 in every cycle without a preceding accepted beat. wdata and waddr hold their last value.

## Timing
- Reset values: state=IDLE, tready=0, wmem_we=0, wmem_waddr=0, wmem_wdata=0, busy=0, load_done=0, load_err=0, counters=0.
- Reset asserted mid-LOAD:
  - Immediately forces all reset values.
  - A partial reload is abandoned, with no done pulse.
- cfg_start sampled high in cycle t: tready and busy are 1 from cycle t+1.
- Write latency: a beat accepted in cycle t appears on wmem_we, waddr and wdata in cycle t+1, for exactly one cycle.
- Throughput: one word per cycle while tvalid stays high. N beats take N cycles in LOAD.
- Exit on the final or early-tlast beat accepted in cycle t:
  - tready=0 and busy=0 in cycle t+1.
  - load_done=1 in cycle t+1, the same cycle as the last write strobe.
  - load_err is updated in cycle t+1.
- cfg_start in the same cycle as the exit beat is ignored, because the state is still LOAD.
- A new cfg_start is honoured from cycle t+1 onward.
- tvalid deassertion mid-load: counters and outputs hold with wmem_we=0, and there is no timeout.
- load_err stays set until the next accepted cfg_start or reset.

## Test plan
- Defaults, cfg_start, then 8 back-to-back beats 0x0..0x3 (repeating) with tlast on beat 8 → write sequence (we,addr) = (01,0),(10,0),(01,1),(10,1)…(10,3). Each write lags its acceptance by 1 cycle. load_done pulses with beat 8's write, and load_err=0.
- Same load with tvalid toggling every other cycle → identical write sequence, with wmem_we low on gap cycles, and done asserts exactly 1 cycle after the 8th acceptance.
- tlast on beat 3 → 3 writes (bank0@0, bank1@0, bank0@1), load_done=1, load_err=1, tready=0 afterwards. A subsequent cfg_start clears load_err.
- 8 beats with tlast=0 throughout → 8 writes, load_done=1, load_err=1. A 9th tvalid beat is not accepted (tready=0).
- areset pulsed after beat 4 → all outputs return to reset values asynchronously with no done pulse. A fresh cfg_start then reloads from bank0@0.
- cfg_start asserted during LOAD and on the final beat's cycle → no counter restart, and the load completes normally.

Source files
------------

// File: rtl/mvau_weight_loader.sv
// mvau_weight_loader
// Runtime writer for the MVAU PE weight banks. Weight words arrive on an
// AXI-Stream slave in address-major order (for each address, bank 0..PE-1)
// and are written into the banks one cycle after acceptance. While a reload
// is in flight wmem_busy holds off MVAU compute.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no reload; stream stalled (tready=0), waiting for cfg_start
// S_LOAD | reload in flight; one beat accepted per cycle with tvalid high
//
// A reload ends on the final beat (last bank, last address) or on an early
// tlast. A final beat without tlast, or a tlast before the final beat, marks
// a framing error in the sticky load_err flag. load_done pulses on every
// exit from S_LOAD, in the same cycle as the last write strobe.

module mvau_weight_loader #(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int PE           = 2,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    cfg_start,
    input  logic [SIMD*TW-1:0]      s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [PE-1:0]           wmem_we,
    output logic [WMEM_ADDR_BW-1:0] wmem_waddr,
    output logic [SIMD*TW-1:0]      wmem_wdata,
    output logic                    wmem_busy,
    output logic                    load_done,
    output logic                    load_err
);

    localparam int                    PE_BW     = (PE > 1) ? $clog2(PE) : 1;
    localparam logic [PE_BW-1:0]        PE_LAST   = PE_BW'(PE - 1);
    localparam logic [WMEM_ADDR_BW-1:0] ADDR_LAST = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_tready;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic [PE-1:0]           r_we;
    logic [WMEM_ADDR_BW-1:0] r_waddr;
    logic [SIMD*TW-1:0]      r_wdata;
    logic [PE_BW-1:0]        r_pe_cnt;
    logic [WMEM_ADDR_BW-1:0] r_addr_cnt;

    logic                    w_accept;
    logic                    w_pe_last;
    logic                    w_addr_last;
    logic                    w_final;
    logic                    w_exit;
    logic [PE-1:0]           w_we_onehot;

    // Beat acceptance and end-of-reload detection
    assign w_accept    = s_axis_tvalid & r_tready;
    assign w_pe_last   = (r_pe_cnt == PE_LAST);
    assign w_addr_last = (r_addr_cnt == ADDR_LAST);
    assign w_final     = w_pe_last & w_addr_last;
    assign w_exit      = w_accept & (w_final | s_axis_tlast);

    // Bank select for the beat currently presented
    always_comb begin
        w_we_onehot = '0;
        w_we_onehot[r_pe_cnt] = 1'b1;
    end

    // Reload FSM with registered stream handshake, write port and status
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state    <= S_IDLE;
            r_tready   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_we       <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_pe_cnt   <= '0;
            r_addr_cnt <= '0;
        end else begin
            r_we   <= '0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_state    <= S_LOAD;
                        r_tready   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_err      <= 1'b0;
                        r_pe_cnt   <= '0;
                        r_addr_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_we    <= w_we_onehot;
                        r_waddr <= r_addr_cnt;
                        r_wdata <= s_axis_tdata;
                        if (w_pe_last) begin
                            r_pe_cnt   <= '0;
                            r_addr_cnt <= w_addr_last ? '0 : r_addr_cnt + WMEM_ADDR_BW'(1);
                        end else begin
                            r_pe_cnt <= r_pe_cnt + PE_BW'(1);
                        end
                        if (w_exit) begin
                            r_state  <= S_IDLE;
                            r_tready <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            // framing is good only when tlast marks exactly the final beat
                            if (w_final != s_axis_tlast) begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_tready <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_tready = r_tready;
    assign wmem_busy     = r_busy;
    assign load_done     = r_done;
    assign load_err      = r_err;
    assign wmem_we       = r_we;
    assign wmem_waddr    = r_waddr;
    assign wmem_wdata    = r_wdata;

endmodule

// File: tb/tb_mvau_weight_loader.sv
// Bench for mvau_weight_loader: a beat-index reference model predicts every
// output each cycle; directed loads plus randomized loads exercise it.

module tb_mvau_weight_loader;

    localparam int SIMD  = 2;
    localparam int TW    = 1;
    localparam int PE    = 2;
    localparam int DEPTH = 4;
    localparam int ABW   = 4;
    localparam int DW    = SIMD * TW;
    localparam int N     = PE * DEPTH;

    logic           aclk = 1'b0;
    logic           areset = 1'b1;
    logic           cfg_start = 1'b0;
    logic [DW-1:0]  s_axis_tdata = '0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tlast = 1'b0;
    logic           s_axis_tready;
    logic [PE-1:0]  wmem_we;
    logic [ABW-1:0] wmem_waddr;
    logic [DW-1:0]  wmem_wdata;
    logic           wmem_busy;
    logic           load_done;
    logic           load_err;

    mvau_weight_loader #(
        .SIMD(SIMD), .TW(TW), .PE(PE), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(ABW)
    ) dut (
        .aclk(aclk), .areset(areset), .cfg_start(cfg_start),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .wmem_we(wmem_we), .wmem_waddr(wmem_waddr), .wmem_wdata(wmem_wdata),
        .wmem_busy(wmem_busy), .load_done(load_done), .load_err(load_err)
    );

    initial forever #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a reload is a count of beats k; beat k goes to bank
    // k % PE at address k / PE.
    bit            m_load = 0;
    int            m_k = 0;
    bit            m_err = 0;
    logic [PE-1:0] e_we = '0;
    int            e_waddr = 0;
    logic [DW-1:0] e_wdata = '0;
    bit            e_done = 0;

    initial forever begin
        @(posedge aclk or posedge areset);
        if (areset) begin
            m_load = 0; m_k = 0; m_err = 0;
            e_we = '0; e_waddr = 0; e_wdata = '0; e_done = 0;
        end else begin
            e_we = '0;
            e_done = 0;
            if (!m_load) begin
                if (cfg_start) begin
                    m_load = 1; m_k = 0; m_err = 0;
                end
            end else if (s_axis_tvalid) begin
                bit is_final;
                is_final = (m_k == N - 1);
                e_we = PE'(1) << (m_k % PE);
                e_waddr = m_k / PE;
                e_wdata = s_axis_tdata;
                m_k++;
                if (is_final || s_axis_tlast) begin
                    m_load = 0;
                    e_done = 1;
                    if (is_final != s_axis_tlast) m_err = 1;
                end
            end
        end
    end

    // Observed write log for literal checks
    int log_we[$];
    int log_addr[$];
    int log_data[$];
    int done_at = -1;

    task automatic clear_log();
        log_we.delete(); log_addr.delete(); log_data.delete();
        done_at = -1;
    endtask

    // Per-cycle comparison of every output against the model
    initial forever begin
        @(negedge aclk);
        chk("cyc_tready", 32'(s_axis_tready), 32'(m_load));
        chk("cyc_busy",   32'(wmem_busy),     32'(m_load));
        chk("cyc_we",     32'(wmem_we),       32'(e_we));
        chk("cyc_waddr",  32'(wmem_waddr),    32'(e_waddr));
        chk("cyc_wdata",  32'(wmem_wdata),    32'(e_wdata));
        chk("cyc_done",   32'(load_done),     32'(e_done));
        chk("cyc_err",    32'(load_err),      32'(m_err));
        if (wmem_we != '0) begin
            log_we.push_back(int'(wmem_we));
            log_addr.push_back(int'(wmem_waddr));
            log_data.push_back(int'(wmem_wdata));
        end
        if (load_done) done_at = log_we.size();
    end

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic start();
        cfg_start = 1'b1;
        @(posedge aclk); #1;
        cfg_start = 1'b0;
    endtask

    // Sends n beats; tlast on beat last_at (1-based, 0 = never).
    task automatic send(input int n, input int last_at, input bit gaps,
                        input bit rnd, input bit hold_start, input bit expect_ok);
        for (int i = 0; i < n; i++) begin
            int waited = 0;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = rnd ? DW'($urandom) : DW'(i % 4);
            s_axis_tlast  = (i + 1 == last_at);
            cfg_start     = hold_start;
            while (!s_axis_tready && waited < 4) begin
                @(posedge aclk); #1;
                waited++;
            end
            chk("beat_tready", 32'(s_axis_tready), 32'(expect_ok));
            if (!s_axis_tready) break;
            @(posedge aclk); #1;
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            cfg_start     = 1'b0;
            if (gaps || (rnd && $urandom_range(0, 2) == 0)) begin
                @(posedge aclk); #1;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        cfg_start     = 1'b0;
    endtask

    int lit_we[8]   = '{1, 2, 1, 2, 1, 2, 1, 2};
    int lit_addr[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int lit_data[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    task automatic chk_seq(input string tag, input int n);
        chk({tag, "_nwrites"}, 32'(log_we.size()), 32'(n));
        for (int i = 0; i < n && i < log_we.size(); i++) begin
            chk({tag, "_we"},   32'(log_we[i]),   32'(lit_we[i]));
            chk({tag, "_addr"}, 32'(log_addr[i]), 32'(lit_addr[i]));
        end
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        #2 areset = 1'b0;
        @(posedge aclk); #1;
        chk("reset_tready", 32'(s_axis_tready), 0);
        chk("reset_busy",   32'(wmem_busy), 0);

        // back-to-back full reload
        clear_log(); start();
        send(8, 8, 0, 0, 0, 1); idle(3);
        chk_seq("t1", 8);
        for (int i = 0; i < 8 && i < log_data.size(); i++)
            chk("t1_data", 32'(log_data[i]), 32'(lit_data[i]));
        chk("t1_done_at", 32'(done_at), 8);
        chk("t1_err", 32'(load_err), 0);

        // tvalid toggling
        clear_log(); start();
        send(8, 8, 1, 0, 0, 1); idle(3);
        chk_seq("t2", 8);
        chk("t2_done_at", 32'(done_at), 8);

        // early tlast on beat 3
        clear_log(); start();
        send(3, 3, 0, 0, 0, 1); idle(2);
        chk_seq("t3", 3);
        chk("t3_done_at", 32'(done_at), 3);
        chk("t3_err", 32'(load_err), 1);
        chk("t3_tready", 32'(s_axis_tready), 0);
        start();
        chk("t3_err_cleared", 32'(load_err), 0);
        send(8, 8, 0, 0, 0, 1); idle(2);

        // no tlast at all, then a ninth beat that must stall
        clear_log(); start();
        send(8, 0, 0, 0, 0, 1); idle(1);
        chk_seq("t4", 8);
        chk("t4_err", 32'(load_err), 1);
        send(1, 0, 0, 0, 0, 0); idle(1);
        chk("t4_nwrites_after", 32'(log_we.size()), 8);

        // async reset mid-load
        clear_log(); start();
        send(4, 0, 0, 0, 0, 1);
        #1 areset = 1'b1;
        #1;
        chk("t5_we",     32'(wmem_we), 0);
        chk("t5_waddr",  32'(wmem_waddr), 0);
        chk("t5_wdata",  32'(wmem_wdata), 0);
        chk("t5_tready", 32'(s_axis_tready), 0);
        chk("t5_busy",   32'(wmem_busy), 0);
        chk("t5_done",   32'(load_done), 0);
        chk("t5_err",    32'(load_err), 0);
        @(posedge aclk); #2 areset = 1'b0;
        @(posedge aclk); #1;
        chk("t5_no_done", 32'(done_at), 32'(-1));
        clear_log(); start();
        send(8, 8, 0, 0, 0, 1); idle(2);
        chk_seq("t5_reload", 8);

        // cfg_start held through the load, including the final beat
        clear_log(); start();
        send(8, 8, 0, 0, 1, 1); idle(3);
        chk_seq("t6", 8);
        chk("t6_done_at", 32'(done_at), 8);
        chk("t6_busy", 32'(wmem_busy), 0);

        // randomized loads
        repeat (20) begin
            int n;
            int last;
            n = $urandom_range(1, N);
            last = (n < N) ? n : ($urandom_range(0, 1) == 0 ? 0 : N);
            clear_log(); start();
            send(n, last, 0, 1, bit'($urandom_range(0, 1)), 1);
            idle(2);
            chk("rnd_nwrites", 32'(log_we.size()), 32'(n));
            chk("rnd_done_at", 32'(done_at), 32'(n));
            chk("rnd_busy", 32'(wmem_busy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
